// File: rtl/mru_snapshot_serializer.sv
// Captures the MRU list and valid mask into a shadow register, then streams valid entries
// in recency order over valid/ready. Optional popcount output: define MRU_SER_COUNT_EN.
module mru_snapshot_serializer #(
    parameter  int WIDTH = 8,
    parameter  int NUM   = 4,
    localparam int IW    = $clog2(NUM),
    localparam int CW    = $clog2(NUM + 1)
) (
    input  logic                      clk_in,
    input  logic                      rst_in,
    input  logic [NUM-1:0][WIDTH-1:0] list_in,
    input  logic [NUM-1:0]            list_valid_in,
    input  logic                      snap_req_in,
    output logic                      busy_out,
    output logic [WIDTH-1:0]          m_data_out,
    output logic [IW-1:0]             m_index_out,
    output logic                      m_last_out,
    output logic                      m_valid_out,
    input  logic                      m_ready_in,
`ifdef MRU_SER_COUNT_EN
    output logic [CW-1:0]             count_out,
`endif
    output logic                      done_out
);

    typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

    state_t                    state, state_nxt;
    logic [NUM-1:0][WIDTH-1:0] shadow_data;
    logic [NUM-1:0]            shadow_mask;
    logic [NUM-1:0]            cur_onehot;
    logic [IW-1:0]             cur_idx;
    logic                      cur_last;
    logic                      capture;
    logic                      accept;

    // Lowest set bit of the shadow mask is the most recent entry still to send.
    always_comb begin
        cur_idx = '0;
        for (int i = NUM - 1; i >= 0; i--) begin
            if (shadow_mask[i]) cur_idx = IW'(i);
        end
    end

    assign cur_onehot = shadow_mask & (~shadow_mask + NUM'(1));
    assign cur_last   = (shadow_mask != '0) && ((shadow_mask & (shadow_mask - NUM'(1))) == '0);

    assign capture = (state == IDLE) && snap_req_in;
    assign accept  = m_valid_out && m_ready_in;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (snap_req_in) state_nxt = (|list_valid_in) ? SEND : DONE;
            SEND:    if (accept && cur_last) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

`ifdef MRU_SER_COUNT_EN
    function automatic logic [CW-1:0] popcnt(input logic [NUM-1:0] m);
        logic [CW-1:0] s;
        s = '0;
        for (int i = 0; i < NUM; i++) s = s + CW'(m[i]);
        return s;
    endfunction
`endif

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state       <= IDLE;
            shadow_data <= '0;
            shadow_mask <= '0;
`ifdef MRU_SER_COUNT_EN
            count_out   <= '0;
`endif
        end else begin
            state <= state_nxt;
            if (capture) begin
                shadow_data <= list_in;
                shadow_mask <= list_valid_in;
`ifdef MRU_SER_COUNT_EN
                count_out   <= popcnt(list_valid_in);
`endif
            end else if (accept) begin
                shadow_mask <= shadow_mask & ~cur_onehot;
            end
        end
    end

    // All outputs decode registered state only, so valid never follows ready.
    assign m_valid_out = (state == SEND);
    assign busy_out    = (state != IDLE);
    assign done_out    = (state == DONE);
    assign m_last_out  = m_valid_out && cur_last;
    assign m_data_out  = m_valid_out ? shadow_data[cur_idx] : '0;
    assign m_index_out = m_valid_out ? cur_idx : '0;

endmodule

// File: doc/mru_snapshot_serializer.md
Name: mru_snapshot_serializer

Overview:
- Downstream consumer of the MRU list stage.
- On request, atomically captures the NUM-entry MRU list and its per-entry valid mask into a shadow register.
- Streams the valid entries in recency order (index 0 = most recent) over a valid/ready interface, one entry per beat, tagged with list index and last flag.
- Used to dump cache contents to a debug/host port without stalling the MRU stage.

Parameters:
- WIDTH, 8, bit width of one list entry; must match the MRU stage.
- NUM, 4, number of list entries; must match the MRU stage; NUM >= 2.

Ports:
- clk_in  input  1  clock; all logic on rising edge.
- rst_in  input  1  synchronous, active-high reset.
- list_in  input  NUM x WIDTH (packed [NUM-1:0][WIDTH-1:0])  MRU list contents; entry 0 is most recent.
- list_valid_in  input  NUM  per-entry valid mask of list_in.
- snap_req_in  input  1  capture request; sampled only in IDLE.
- busy_out  output  1  high whenever the state is not IDLE.
- m_data_out  output  WIDTH  current entry value.
- m_index_out  output  $clog2(NUM)  list index of current entry.
- m_last_out  output  1  current beat is the last valid entry of the snapshot.
- m_valid_out  output  1  beat valid.
- m_ready_in  input  1  downstream accepts beat.
- done_out  output  1  one-cycle pulse: snapshot fully delivered.

Behaviour:
- Reset (synchronous, rst_in high at a rising edge):
  - State = IDLE.
  - Shadow data and shadow mask = 0.
  - m_valid_out, m_last_out, done_out, busy_out = 0.
  - m_data_out and m_index_out = 0.
  - Reset has priority over every other event. Asserting it mid-SEND aborts the transfer: no done_out, no further beats.
- States: IDLE, SEND, DONE.
- IDLE, snap_req_in=1 at edge k:
  - Shadow captures list_in and list_valid_in.
  - Mask nonzero: go to SEND; m_valid_out high in cycle k+1, presenting the lowest-index set bit.
  - Mask zero: go to DONE; done_out high in cycle k+1 and no beat is ever asserted.
- SEND:
  - m_data_out/m_index_out present the lowest-index set bit of the shadow mask.
  - m_last_out = 1 iff exactly one bit remains set.
  - On m_valid_out & m_ready_in: clear that bit.
    - If it was the last beat: go to DONE and drop m_valid_out next cycle.
    - Otherwise present the next set bit in the following cycle (no bubble while m_ready_in stays high).
  - Invalid entries are skipped with no idle cycle. Non-contiguous masks are legal.
- Handshake rules:
  - Once m_valid_out is high, it and m_data_out/m_index_out/m_last_out stay stable until accepted.
  - m_valid_out never depends combinationally on m_ready_in.
- DONE: done_out = 1 for exactly one cycle, then IDLE. A snap_req_in in the DONE cycle is ignored.
- snap_req_in during SEND or DONE is ignored; it is not queued.
- The snapshot is isolated: changes on list_in/list_valid_in after capture do not affect output.
- Throughput: n valid entries take n beats. Capture to done_out = n+1 cycles with m_ready_in held high.
- Index arithmetic is unsigned, width $clog2(NUM). The next-set-bit search is a combinational priority encoder over the shadow mask.

Optional Feature:
- Macro MRU_SER_COUNT_EN.
- Defined:
  - Adds output port count_out, width $clog2(NUM+1): popcount of the captured mask.
  - Loaded at the capture edge; holds until the next capture; reset value 0.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
- Full list (NUM=4, WIDTH=8), entries 0x11,0x22,0x33,0x44, mask 4'b1111, m_ready_in=1, snap_req_in pulse at edge k -> beats 0x11/idx0, 0x22/idx1, 0x33/idx2, 0x44/idx3 in cycles k+1..k+4; m_last_out only with 0x44; done_out in cycle k+5; count_out=4 if MRU_SER_COUNT_EN.
- Sparse mask 4'b1010, same data -> exactly two beats, 0x22/idx1 then 0x44/idx3 (last), back-to-back.
- Empty mask 4'b0000 -> m_valid_out never asserted; done_out high in cycle k+1 only; busy_out high in cycle k+1 only.
- Backpressure: full list, m_ready_in low for 3 cycles while 0x22 is presented -> 0x22/idx1 held stable for 4 cycles, accepted once; remaining beats follow; total beats = 4.
- Isolation: during SEND, change list_in to all 0xFF and pulse snap_req_in -> output continues with the original snapshot; no second transfer starts.
- Reset mid-transfer after 0x11 accepted -> m_valid_out=0 and busy_out=0 the cycle after reset; no done_out; a new snap_req_in then streams a fresh snapshot from idx0.
